// File: rtl/pause_pkg.sv
// Shared types and constants for the core pause/resume controller.
// Imported by the interface-facing top and by the per-core FSM.
package pause_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        HALTED = 2'd2
    } pause_state_t;

    localparam logic [2:0] STALL_ALL  = 3'd7;
    localparam logic [2:0] STALL_NONE = 3'd0;

    // Bit positions inside one core's 3-bit pause_resume field
    localparam int PR_VALID  = 2;
    localparam int PR_RESUME = 1;
    localparam int PR_TARGET = 0;

endpackage

// File: rtl/core_pause_ctrl_if.sv
// Bundle between the cores' write-back stages and the pause controller.
// master = core side, slave = controller side.
interface core_pause_ctrl_if #(
    parameter int NCORES = 2,
    parameter int CNT_W  = 16
);
    logic [3*NCORES-1:0]     pause_resume;
    logic [NCORES-1:0]       halt;
    logic [3*NCORES-1:0]     stall_num;
    logic [2*NCORES-1:0]     core_state;
    logic                    deadlock;
    logic [CNT_W*NCORES-1:0] paused_cycles;

    modport master (
        output pause_resume, halt,
        input  stall_num, core_state, deadlock, paused_cycles
    );

    modport slave (
        input  pause_resume, halt,
        output stall_num, core_state, deadlock, paused_cycles
    );
endinterface

// File: rtl/pause_fsm.sv
// Per-core RUN/PAUSED/HALTED state with registered stall_num and a
// saturating counter of cycles spent PAUSED.
module pause_fsm
    import pause_pkg::*;
#(
    parameter bit START_PAUSED = 1'b0,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pause_hit,
    input  logic             resume_hit,
    input  logic             halt,
    output pause_state_t     state,
    output logic [2:0]       stall_num,
    output logic [CNT_W-1:0] paused_cycles
);

    localparam pause_state_t     RESET_STATE = START_PAUSED ? PAUSED : RUN;
    localparam logic [2:0]       RESET_STALL = START_PAUSED ? STALL_ALL : STALL_NONE;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    pause_state_t     state_reg, state_next;
    logic [2:0]       stall_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Halt overrides any pause/resume decoded in the same cycle
    always_comb begin
        state_next = state_reg;
        if (halt) begin
            state_next = HALTED;
        end else begin
            case (state_reg)
                RUN:     if (pause_hit)  state_next = PAUSED;
                PAUSED:  if (resume_hit) state_next = RUN;
                default: state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RESET_STATE;
            stall_reg <= RESET_STALL;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            stall_reg <= (state_next == RUN) ? STALL_NONE : STALL_ALL;
            if (state_reg == PAUSED && cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign state         = state_reg;
    assign stall_num     = stall_reg;
    assign paused_cycles = cnt_reg;

endmodule

// File: rtl/core_pause_ctrl.sv
// Pause/resume controller: per-requester edge detection, lowest-index
// arbitration per target core, per-core FSMs and a sticky deadlock flag.
module core_pause_ctrl
    import pause_pkg::*;
#(
    parameter int                NCORES       = 2,
    parameter logic [NCORES-1:0] START_PAUSED = 2'b10,
    parameter int                CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    core_pause_ctrl_if.slave bus
);

    logic [NCORES-1:0] evt;
    logic [NCORES-1:0] pause_hit;
    logic [NCORES-1:0] resume_hit;
    logic [NCORES-1:0] granted;
    logic [NCORES-1:0] is_paused;
    logic [NCORES-1:0] is_halted;
    logic              deadlock_reg;

    generate
        for (genvar gi = 0; gi < NCORES; gi++) begin : g_core
            logic [2:0]       req;
            logic [2:0]       prev_reg;
            logic [2:0]       stall;
            logic [CNT_W-1:0] cycles;
            pause_state_t     state;

            assign req = bus.pause_resume[3*gi +: 3];

            // A stalled requester repeats its instruction, so only a change counts
            assign evt[gi] = req[PR_VALID] && (req != prev_reg) && (state != HALTED);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prev_reg <= '0;
                end else begin
                    prev_reg <= req;
                end
            end

            pause_fsm #(
                .START_PAUSED (START_PAUSED[gi]),
                .CNT_W        (CNT_W)
            ) u_fsm (
                .clk           (clk),
                .rst_n         (rst_n),
                .pause_hit     (pause_hit[gi]),
                .resume_hit    (resume_hit[gi]),
                .halt          (bus.halt[gi]),
                .state         (state),
                .stall_num     (stall),
                .paused_cycles (cycles)
            );

            assign is_paused[gi]                        = (state == PAUSED);
            assign is_halted[gi]                        = (state == HALTED);
            assign bus.stall_num[3*gi +: 3]             = stall;
            assign bus.core_state[2*gi +: 2]            = state;
            assign bus.paused_cycles[CNT_W*gi +: CNT_W] = cycles;
        end
    endgenerate

    // Per target, the lowest-index requester wins; losers are dropped
    always_comb begin
        pause_hit  = '0;
        resume_hit = '0;
        granted    = '0;
        for (int t = 0; t < NCORES; t++) begin
            for (int r = 0; r < NCORES; r++) begin
                if (!granted[t] && evt[r] &&
                    (bus.pause_resume[3*r+PR_TARGET] == t[0])) begin
                    granted[t]    = 1'b1;
                    resume_hit[t] = bus.pause_resume[3*r+PR_RESUME];
                    pause_hit[t]  = !bus.pause_resume[3*r+PR_RESUME];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deadlock_reg <= 1'b0;
        end else if ((|(~is_halted)) && (&(is_paused | is_halted))) begin
            deadlock_reg <= 1'b1;
        end
    end

    assign bus.deadlock = deadlock_reg;

endmodule

// File: tb/tb_core_pause_ctrl.sv
// Directed bench for core_pause_ctrl with two cores and 4-bit counters.
// Expected values are hand-derived cycle by cycle.
module tb_core_pause_ctrl;
    import pause_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    core_pause_ctrl_if #(.NCORES(2), .CNT_W(4)) bus ();

    core_pause_ctrl #(
        .NCORES       (2),
        .START_PAUSED (2'b10),
        .CNT_W        (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        $display("check %-22s observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.pause_resume = '0;
        bus.halt         = '0;
        #12;
        chk("rst_state",    32'(bus.core_state),    32'h4);
        chk("rst_stall",    32'(bus.stall_num),     32'h38);
        chk("rst_deadlock", 32'(bus.deadlock),      32'h0);
        chk("rst_cycles",   32'(bus.paused_cycles), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        tick(1);
        chk("p1_cycles1", 32'(bus.paused_cycles[7:4]), 32'd1);

        // core0 resumes core1
        bus.pause_resume = 6'b000_111;
        tick(1);
        chk("resume_state",   32'(bus.core_state),        32'h0);
        chk("resume_stall",   32'(bus.stall_num),         32'h0);
        chk("resume_cycles1", 32'(bus.paused_cycles[7:4]), 32'd2);

        // core0 keeps 111; core1 self-pauses, held value must not resume it
        tick(1);
        bus.pause_resume = 6'b101_111;
        tick(1);
        chk("selfpause_state", 32'(bus.core_state), 32'h4);
        chk("selfpause_stall", 32'(bus.stall_num),  32'h38);
        tick(3);
        chk("hold_state",    32'(bus.core_state),        32'h4);
        chk("hold_cycles1",  32'(bus.paused_cycles[7:4]), 32'd5);
        chk("hold_deadlock", 32'(bus.deadlock),          32'h0);

        // valid low clears history, same code is a fresh event
        bus.pause_resume = 6'b101_000;
        tick(1);
        bus.pause_resume = 6'b101_111;
        tick(1);
        chk("rearm_state",   32'(bus.core_state),        32'h0);
        chk("rearm_cycles1", 32'(bus.paused_cycles[7:4]), 32'd7);

        // re-pause core1, then core0 self-pauses -> deadlock
        bus.pause_resume = 6'b000_111;
        tick(1);
        bus.pause_resume = 6'b101_111;
        tick(1);
        bus.pause_resume = 6'b101_100;
        tick(1);
        chk("both_state",  32'(bus.core_state), 32'h5);
        chk("both_stall",  32'(bus.stall_num),  32'h3f);
        chk("dl_early",    32'(bus.deadlock),   32'h0);
        tick(1);
        chk("dl_set",      32'(bus.deadlock),            32'h1);
        chk("dl_cycles0",  32'(bus.paused_cycles[3:0]),  32'd1);
        chk("dl_cycles1",  32'(bus.paused_cycles[7:4]),  32'd9);

        // core1 resumes core0; deadlock stays
        bus.pause_resume = 6'b110_100;
        tick(1);
        chk("xresume_state", 32'(bus.core_state),        32'h4);
        chk("dl_sticky",     32'(bus.deadlock),          32'h1);
        chk("xresume_cyc0",  32'(bus.paused_cycles[3:0]), 32'd2);
        bus.pause_resume = 6'b110_111;
        tick(1);
        chk("run_all_state", 32'(bus.core_state),        32'h0);
        chk("run_all_cyc1",  32'(bus.paused_cycles[7:4]), 32'd11);

        // simultaneous: core0 resume core1 beats core1 pause core1
        bus.pause_resume = 6'b000_000;
        tick(1);
        bus.pause_resume = 6'b101_111;
        tick(1);
        chk("arb_state", 32'(bus.core_state), 32'h0);
        chk("arb_stall", 32'(bus.stall_num),  32'h0);

        // halt core1 together with a pause to it
        bus.halt         = 2'b10;
        bus.pause_resume = 6'b101_101;
        tick(1);
        chk("halt_state", 32'(bus.core_state), 32'h8);
        chk("halt_stall", 32'(bus.stall_num),  32'h38);
        bus.halt         = 2'b00;
        bus.pause_resume = 6'b101_111;
        tick(1);
        chk("halted_resume_state", 32'(bus.core_state),        32'h8);
        chk("halted_cycles1",      32'(bus.paused_cycles[7:4]), 32'd11);
        bus.pause_resume = 6'b100_111;
        tick(1);
        chk("halted_req_state", 32'(bus.core_state), 32'h8);

        // fresh reset, then saturation of core1 counter
        rst_n            = 1'b0;
        bus.pause_resume = '0;
        bus.halt         = '0;
        #1;
        chk("rst2_state",    32'(bus.core_state), 32'h4);
        chk("rst2_deadlock", 32'(bus.deadlock),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(14);
        chk("cnt_14",    32'(bus.paused_cycles[7:4]), 32'd14);
        tick(6);
        chk("cnt_sat",   32'(bus.paused_cycles[7:4]), 32'd15);
        chk("sat_state", 32'(bus.core_state),         32'h4);
        chk("sat_cyc0",  32'(bus.paused_cycles[3:0]), 32'd0);

        // asynchronous reset mid-pause, no clock edge in between
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_clear", 32'(bus.paused_cycles), 32'h0);

        // halting every core is not a deadlock
        @(negedge clk);
        rst_n    = 1'b1;
        bus.halt = 2'b11;
        tick(1);
        chk("allhalt_state", 32'(bus.core_state), 32'ha);
        chk("allhalt_stall", 32'(bus.stall_num),  32'h3f);
        tick(2);
        chk("allhalt_dl",    32'(bus.deadlock),   32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
